// File: rtl/psum_requant.sv
// psum_requant
//   Accumulates ACC_NUM signed partial sums per output activation. The bias is
//   added with the first partial sum of each group. The group total is then
//   rounded and arithmetically right-shifted. The result is passed through an
//   optional ReLU and saturated to a WDP-bit signed activation.
//
//   Pipeline:
//     Stage A  accumulate      (edge that accepts a psum)
//     Stage B  round/shift     (one edge after the last psum of a group)
//     Stage C  relu/saturate   (two edges after the last psum; q_en pulses)
//
// Ports
//   clk      in   rising-edge clock
//   rstn     in   asynchronous active-low reset
//   psum_en  in   partial-sum valid
//   psum     in   signed partial sum, WDP_IN bits
//   bias     in   signed bias, WDP_BIAS bits, used only with element 0 of a group
//   clr      in   synchronous group abort / frame start
//   q_en     out  one-cycle pulse, q valid
//   q        out  signed requantized activation, WDP bits, held between pulses
//   grp_cnt  out  index of the next expected psum in the current group
module psum_requant #(
  parameter int WDP_IN     = 17,
  parameter int WDP_BIAS   = 13,
  parameter int WDP        = 9,
  parameter int ACC_NUM    = 4,
  parameter int SHIFT      = 2,
  parameter int BIAS_SHIFT = 0,
  parameter int RELU_EN    = 1,
  parameter int WDP_ACC    = WDP_IN + $clog2(ACC_NUM) + 1
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       psum_en,
  input  logic signed [WDP_IN-1:0]   psum,
  input  logic signed [WDP_BIAS-1:0] bias,
  input  logic                       clr,
  output logic                       q_en,
  output logic signed [WDP-1:0]      q,
  output logic [7:0]                 grp_cnt
);

  localparam logic [7:0] LAST_IDX = 8'(ACC_NUM - 1);
  // One guard bit so that adding the rounding constant can never wrap.
  localparam int RW = WDP_ACC + 1;
  localparam logic signed [RW-1:0] Q_MAX = {{(RW-WDP+1){1'b0}}, {(WDP-1){1'b1}}};
  localparam logic signed [RW-1:0] Q_MIN = {{(RW-WDP+1){1'b1}}, {(WDP-1){1'b0}}};

  logic signed [WDP_ACC-1:0] acc_q, acc_d;
  logic [7:0]                grp_cnt_q, grp_cnt_d;
  logic                      done_q;     // acc holds a finished group (Stage B runs)
  logic                      r_vld_q;    // r holds a finished group (Stage C runs)
  logic signed [RW-1:0]      r_q, r_d;
  logic signed [WDP-1:0]     q_q, q_d;
  logic                      q_en_q;

  // ---------------- Stage A: accumulate ----------------
  logic signed [WDP_ACC-1:0] psum_ext;
  logic signed [WDP_ACC-1:0] bias_ext;
  logic [7:0]                idx;
  logic                      last;

  assign psum_ext = {{(WDP_ACC-WDP_IN){psum[WDP_IN-1]}}, psum};
  assign bias_ext = {{(WDP_ACC-WDP_BIAS){bias[WDP_BIAS-1]}}, bias} <<< BIAS_SHIFT;

  // clr together with psum_en makes this psum element 0 of a fresh group.
  assign idx  = clr ? 8'd0 : grp_cnt_q;
  assign last = psum_en && (idx == LAST_IDX);

  always_comb begin
    acc_d     = acc_q;
    grp_cnt_d = grp_cnt_q;
    if (psum_en) begin
      acc_d     = (idx == 8'd0) ? (psum_ext + bias_ext) : (acc_q + psum_ext);
      grp_cnt_d = last ? 8'd0 : (idx + 8'd1);
    end else if (clr) begin
      grp_cnt_d = 8'd0;
    end
  end

  // ---------------- Stage B: round half up, arithmetic shift ----------------
  logic signed [RW-1:0] acc_ext;
  assign acc_ext = {acc_q[WDP_ACC-1], acc_q};

  generate
    if (SHIFT > 0) begin : g_round
      localparam logic signed [RW-1:0] RND = RW'(1) <<< (SHIFT - 1);
      assign r_d = (acc_ext + RND) >>> SHIFT;
    end else begin : g_noround
      assign r_d = acc_ext;
    end
  endgenerate

  // ---------------- Stage C: relu + saturate ----------------
  always_comb begin
    q_d = q_q;
    if (r_vld_q) begin
      if ((RELU_EN != 0) && r_q[RW-1]) begin
        q_d = '0;
      end else if (r_q > Q_MAX) begin
        q_d = Q_MAX[WDP-1:0];
      end else if (r_q < Q_MIN) begin
        q_d = Q_MIN[WDP-1:0];
      end else begin
        q_d = r_q[WDP-1:0];
      end
    end
  end

  // ---------------- state registers ----------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      acc_q     <= '0;
      grp_cnt_q <= '0;
      done_q    <= 1'b0;
      r_vld_q   <= 1'b0;
      r_q       <= '0;
      q_q       <= '0;
      q_en_q    <= 1'b0;
    end else begin
      acc_q     <= acc_d;
      grp_cnt_q <= grp_cnt_d;
      done_q    <= last;
      r_vld_q   <= done_q;
      if (done_q) begin
        r_q <= r_d;
      end
      q_q    <= q_d;
      q_en_q <= r_vld_q;
    end
  end

  assign q_en    = q_en_q;
  assign q       = q_q;
  assign grp_cnt = grp_cnt_q;

endmodule
